// File: rtl/ram_ar_aw_ctrl.sv
// Clocked valid/ready front-end for one port of an asynchronous RAM.
// Sequences cs/we/oe through setup, pulse and hold phases and returns a one-cycle response.
module ram_ar_aw_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int SETUP_CYC  = 1,
    parameter int PULSE_CYC  = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);
    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

    state_t                state, state_d;
    logic [3:0]            cnt, cnt_d;
    logic                  we_q, we_q_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d, cap, cap_d, rdata_d;
    logic                  cs_d, we_d, oe_d, rsp_d;
    logic                  phase_done;

    assign req_ready  = (state == IDLE) && !reset;
    assign phase_done = (cnt == 4'd0);

    // Every ram_* strobe is the registered image of its *_d value, so the
    // RAM never sees a combinational path from the request inputs.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        we_q_d  = we_q;
        addr_d  = ram_address;
        wdata_d = ram_wdata;
        cap_d   = cap;
        rdata_d = rsp_rdata;
        cs_d    = ram_cs;
        we_d    = ram_we;
        oe_d    = ram_oe;
        rsp_d   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                    we_q_d  = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cs_d    = 1'b1;
                end
            end
            SETUP: begin
                if (phase_done) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LD;
                    we_d    = we_q;
                    oe_d    = !we_q;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            PULSE: begin
                if (phase_done) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                    we_d    = 1'b0;
                    oe_d    = 1'b0;
                    // Only sample point for ram_rdata: last cycle of the oe pulse.
                    if (!we_q) cap_d = ram_rdata;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (phase_done) begin
                    state_d = IDLE;
                    cs_d    = 1'b0;
                    rsp_d   = 1'b1;
                    rdata_d = we_q ? '0 : cap;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            we_q        <= 1'b0;
            ram_address <= '0;
            ram_wdata   <= '0;
            cap         <= '0;
            rsp_rdata   <= '0;
            rsp_valid   <= 1'b0;
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            ram_oe      <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            we_q        <= we_q_d;
            ram_address <= addr_d;
            ram_wdata   <= wdata_d;
            cap         <= cap_d;
            rsp_rdata   <= rdata_d;
            rsp_valid   <= rsp_d;
            ram_cs      <= cs_d;
            ram_we      <= we_d;
            ram_oe      <= oe_d;
        end
    end
endmodule

// File: tb/tb_ram_ar_aw_ctrl.sv
// Bench for ram_ar_aw_ctrl: default-timing instance and a 3/4/2 instance against a RAM model,
// with a transaction-level reference (expected phases from S/P/H, expected data from an array).
module tb_ram_ar_aw_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sel = 1'b0;
    logic       req_valid = 1'b0, req_we = 1'b0;
    logic [7:0] req_addr = 8'h0, req_wdata = 8'h0;

    logic       ready0, ready1, rv0, rv1, cs0, cs1, we0, we1, oe0, oe1;
    logic [7:0] rd0, rd1, ad0, ad1, wd0, wd1, rr0, rr1;
    logic [7:0] junk = 8'h0;
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    bit         wv0 [256];
    bit         wv1 [256];

    logic [7:0] ref_mem [2][256];
    int n_tests = 0, n_fail = 0, cyc = 0, last_acc = 0, last_n = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] dflt(input logic [7:0] a);
        return (a == 8'h77) ? 8'h5A : (a ^ 8'hC3);
    endfunction

    // RAM model: write committed on clock edges during we; read data only
    // valid while cs & oe, otherwise random junk to expose stray sampling.
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        junk <= 8'($urandom);
        if (cs0 && we0) begin mem0[ad0] <= wd0; wv0[ad0] <= 1'b1; end
        if (cs1 && we1) begin mem1[ad1] <= wd1; wv1[ad1] <= 1'b1; end
    end
    assign rr0 = (cs0 && oe0) ? (wv0[ad0] ? mem0[ad0] : dflt(ad0)) : junk;
    assign rr1 = (cs1 && oe1) ? (wv1[ad1] ? mem1[ad1] : dflt(ad1)) : junk;

    ram_ar_aw_ctrl u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(ready0),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv0), .rsp_rdata(rd0), .ram_address(ad0), .ram_wdata(wd0),
        .ram_rdata(rr0), .ram_cs(cs0), .ram_we(we0), .ram_oe(oe0)
    );

    ram_ar_aw_ctrl #(.SETUP_CYC(3), .PULSE_CYC(4), .HOLD_CYC(2)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(ready1),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_rdata(rd1), .ram_address(ad1), .ram_wdata(wd1),
        .ram_rdata(rr1), .ram_cs(cs1), .ram_we(we1), .ram_oe(oe1)
    );

    logic       ob_ready, ob_rv, ob_cs, ob_we, ob_oe;
    logic [7:0] ob_rd, ob_ad, ob_wd;
    assign ob_ready = sel ? ready1 : ready0;
    assign ob_rv    = sel ? rv1 : rv0;
    assign ob_cs    = sel ? cs1 : cs0;
    assign ob_we    = sel ? we1 : we0;
    assign ob_oe    = sel ? oe1 : oe0;
    assign ob_rd    = sel ? rd1 : rd0;
    assign ob_ad    = sel ? ad1 : ad0;
    assign ob_wd    = sel ? wd1 : wd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Strobe protocol checker on both instances.
    logic       pcs0 = 1'b0, pcs1 = 1'b0;
    logic [7:0] pad0 = 8'h0, pwd0 = 8'h0, pad1 = 8'h0, pwd1 = 8'h0;
    always @(negedge clk) begin
        if (!reset) begin
            chk("we_and_oe0", 32'(we0 & oe0), 0);
            chk("strobe_wo_cs0", 32'((we0 | oe0) & ~cs0), 0);
            chk("we_and_oe1", 32'(we1 & oe1), 0);
            chk("strobe_wo_cs1", 32'((we1 | oe1) & ~cs1), 0);
            if (cs0 && pcs0) begin
                chk("addr_stable0", 32'(ad0), 32'(pad0));
                chk("wdata_stable0", 32'(wd0), 32'(pwd0));
            end
            if (cs1 && pcs1) begin
                chk("addr_stable1", 32'(ad1), 32'(pad1));
                chk("wdata_stable1", 32'(wd1), 32'(pwd1));
            end
        end
        pcs0 <= cs0; pad0 <= ad0; pwd0 <= wd0;
        pcs1 <= cs1; pad1 <= ad1; pwd1 <= wd1;
    end

    // One transaction, entered at a falling edge; returns at the falling edge
    // of the response cycle so a following call can be accepted back-to-back.
    task automatic txn(input bit s1, input bit we, input logic [7:0] a, input logic [7:0] d,
                       input bit hold, input bit b2b);
        int s, p, h, n, waits, acc;
        logic [7:0] exp;
        s = s1 ? 3 : 1;
        p = s1 ? 4 : 2;
        h = s1 ? 2 : 1;
        n = s + p + h + 1;
        sel = s1; req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        waits = 0;
        while (!ob_ready && waits < 40) begin @(negedge clk); waits++; end
        chk("accept_wait", 32'(waits < 40), 1);
        if (waits >= 40) begin req_valid = 1'b0; return; end
        acc = cyc;
        if (b2b) chk("accept_gap", 32'(acc - last_acc), 32'(last_n));
        last_acc = acc;
        last_n = n;
        exp = we ? 8'h00 : ref_mem[s1][a];
        if (we) ref_mem[s1][a] = d;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
            req_addr = 8'($urandom); req_wdata = 8'($urandom); req_we = 1'($urandom);
            chk("cs", 32'(ob_cs), 32'(k <= s + p + h));
            chk("we", 32'(ob_we), 32'(we && k > s && k <= s + p));
            chk("oe", 32'(ob_oe), 32'(!we && k > s && k <= s + p));
            chk("rsp_valid", 32'(ob_rv), 32'(k == n));
            chk("req_ready", 32'(ob_ready), 32'(k == n));
            chk("ram_address", 32'(ob_ad), 32'(a));
            if (we) chk("ram_wdata", 32'(ob_wd), 32'(d));
            if (k == n) chk("rsp_rdata", 32'(ob_rd), 32'(exp));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        bit s1, we, hold;
        logic [7:0] a, d;
        for (int i = 0; i < 256; i++) begin
            ref_mem[0][i] = dflt(8'(i));
            ref_mem[1][i] = dflt(8'(i));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready0), 0);
        chk("rst_rsp_valid", 32'(rv0), 0);
        chk("rst_rsp_rdata", 32'(rd0), 0);
        chk("rst_ram_address", 32'(ad0), 0);
        chk("rst_ram_wdata", 32'(wd0), 0);
        chk("rst_strobes", 32'({cs0, we0, oe0}), 0);
        chk("rst_ready1", 32'(ready1), 0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("ready_after_rst", 32'(ready0), 1);
        @(negedge clk);

        // write then read
        txn(0, 1, 8'h3C, 8'hA5, 0, 0);
        txn(0, 0, 8'h3C, 8'h00, 0, 1);
        // back-to-back writes incl. top address, then reads
        txn(0, 1, 8'h00, 8'h11, 0, 1);
        txn(0, 1, 8'h01, 8'h22, 0, 1);
        txn(0, 1, 8'hFF, 8'h33, 0, 1);
        txn(0, 0, 8'h00, 8'h00, 0, 1);
        txn(0, 0, 8'h01, 8'h00, 0, 1);
        txn(0, 0, 8'hFF, 8'h00, 0, 1);
        // 3/4/2 timing instance reading preloaded 0x5A
        txn(1, 0, 8'h77, 8'h00, 0, 1);
        // req_valid held high with changing inputs while busy
        txn(0, 1, 8'h40, 8'h9C, 1, 1);
        txn(0, 1, 8'h41, 8'h6B, 1, 1);
        txn(0, 0, 8'h40, 8'h00, 1, 1);
        txn(0, 0, 8'h41, 8'h00, 0, 1);

        for (int i = 0; i < 40; i++) begin
            s1   = ($urandom_range(3) == 0);
            we   = 1'($urandom);
            a    = 8'($urandom);
            d    = 8'($urandom);
            hold = 1'($urandom);
            gap  = $urandom_range(2);
            if (gap > 0) begin
                req_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            txn(s1, we, a, d, hold, gap == 0);
        end
        req_valid = 1'b0;
        @(negedge clk);

        // reset in cycle 2 of a write
        sel = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h90; req_wdata = 8'hEE;
        chk("rst_txn_ready", 32'(ready0), 1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_txn_pre_we", 32'(we0), 1);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_strobes", 32'({cs0, we0, oe0}), 0);
        chk("rst_async_ready", 32'(ready0), 0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_held_rsp", 32'(rv0), 0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1 chk("rst_release_ready", 32'(ready0), 1);
        repeat (6) begin
            @(negedge clk);
            chk("rst_no_rsp", 32'(rv0), 0);
        end
        txn(0, 0, 8'h91, 8'h00, 0, 0);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
